// File: rtl/uart_tx_arbiter.sv
// Two-requester UART transmitter: round-robin arbitration in IDLE, then one
// 8N1 frame (start, 8 data bits LSB first, stop) at FREQ_DIV clocks per bit.
`ifndef UART_FREQ_DIV
`define UART_FREQ_DIV 4
`endif

module uart_tx_arbiter #(
    parameter int FREQ_DIV = `UART_FREQ_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       txd,
    output logic       busy,
    output logic       grant_id,
    output logic       frame_done
);

    localparam int DIV_W = (FREQ_DIV > 2) ? $clog2(FREQ_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FREQ_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             last_grant_q, last_grant_d;
    logic             grant_id_q, grant_id_d;
    logic             txd_q, txd_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;

    logic             win;
    logic [7:0]       win_data;
    logic             accept;
    logic             bit_end;

    // With both requesters waiting, the one not served last time wins.
    always_comb begin
        if (req0_valid && req1_valid) begin
            win = ~last_grant_q;
        end else begin
            win = req1_valid;
        end
        win_data = win ? req1_data : req0_data;
        accept   = (state_q == ST_IDLE) && (req0_valid || req1_valid) && !rst;
        bit_end  = (div_cnt_q == DIV_LAST);
    end

    assign req0_ready = accept && !win;
    assign req1_ready = accept && win;

    // NOTE: every variable gets its hold value first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        div_cnt_d    = div_cnt_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shift_d      = win_data;
                    grant_id_d   = win;
                    last_grant_d = win;
                    bit_cnt_d    = 3'd0;
                    div_cnt_d    = '0;
                    state_d      = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    div_cnt_d = '0;
                    state_d   = ST_DATA;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    div_cnt_d = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    div_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Registered outputs are derived from the next state so the line
        // changes on the same edge the state does.
        txd_d        = 1'b1;
        if (state_d == ST_START) begin
            txd_d = 1'b0;
        end else if (state_d == ST_DATA) begin
            txd_d = shift_d[0];
        end
        busy_d       = (state_d != ST_IDLE);
        frame_done_d = (state_d == ST_STOP) && (div_cnt_d == DIV_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shift_q      <= 8'd0;
            bit_cnt_q    <= 3'd0;
            div_cnt_q    <= '0;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            txd_q        <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            div_cnt_q    <= div_cnt_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            txd_q        <= txd_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign txd        = txd_q;
    assign busy       = busy_q;
    assign grant_id   = grant_id_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte queues feed the DUT, and a
// queue-level round-robin model predicts each frame's source and waveform.
module tb_uart_tx_arbiter;

    localparam int FD    = 4;
    localparam int FRAME = 10 * FD;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_data  = 8'd0;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_data  = 8'd0;
    logic       req0_ready, req1_ready, txd, busy, grant_id, frame_done;

    int assertions = 0;
    int failures   = 0;
    int cyc        = 0;

    logic [7:0] drv_q0[$];
    logic [7:0] drv_q1[$];
    logic [7:0] mdl_q0[$];
    logic [7:0] mdl_q1[$];
    bit         acc0 = 1'b0;
    bit         acc1 = 1'b0;
    bit         m_last = 1'b1;
    bit         m_gid  = 1'b0;

    uart_tx_arbiter #(.FREQ_DIV(FD)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .txd        (txd),
        .busy       (busy),
        .grant_id   (grant_id),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Requester drivers: present the queue head, pop it once a handshake was seen.
    always @(negedge clk) begin
        logic [7:0] dummy;
        if (acc0 && drv_q0.size() != 0) dummy = drv_q0.pop_front();
        if (acc1 && drv_q1.size() != 0) dummy = drv_q1.pop_front();
        req0_valid = (drv_q0.size() != 0);
        req0_data  = req0_valid ? drv_q0[0] : 8'($urandom);
        req1_valid = (drv_q1.size() != 0);
        req1_data  = req1_valid ? drv_q1[0] : 8'($urandom);
        #1;
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;
    end

    // Ready rules that must hold in every cycle.
    always @(posedge clk) begin
        #4;
        assertions++;
        if ((req0_ready && req1_ready) || (req0_ready && !req0_valid) ||
            (req1_ready && !req1_valid) || (busy && (req0_ready || req1_ready))) begin
            failures++;
            $display("FAIL ready_rules cyc %0d: ready0=%b ready1=%b valid0=%b valid1=%b busy=%b, required at most one ready, only for a valid requester, none while busy",
                     cyc, req0_ready, req1_ready, req0_valid, req1_valid, busy);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog");
    end

    task automatic push(input bit who, input logic [7:0] d);
        if (who) begin
            drv_q1.push_back(d);
            mdl_q1.push_back(d);
        end else begin
            drv_q0.push_back(d);
            mdl_q0.push_back(d);
        end
    endtask

    task automatic predict(output bit gid, output logic [7:0] d);
        if (mdl_q0.size() != 0 && mdl_q1.size() != 0) gid = !m_last;
        else gid = (mdl_q1.size() != 0);
        d      = gid ? mdl_q1.pop_front() : mdl_q0.pop_front();
        m_last = gid;
        m_gid  = gid;
    endtask

    task automatic check_quiet(input string tag);
        assertions++;
        if (txd !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0 ||
            req0_ready !== 1'b0 || req1_ready !== 1'b0 || grant_id !== m_gid) begin
            failures++;
            $display("FAIL %s cyc %0d: txd=%b busy=%b frame_done=%b ready0=%b ready1=%b grant_id=%b, required 1 0 0 0 0 %b",
                     tag, cyc, txd, busy, frame_done, req0_ready, req1_ready, grant_id, m_gid);
        end
    endtask

    // Waits for a start bit, then checks all 40 frame cycles and the idle gap.
    task automatic frame_check(input bit exp_gid, input logic [7:0] exp_byte,
                               input string tag, output int start_cyc);
        int   waited;
        int   b;
        logic exp_txd;
        waited    = 0;
        start_cyc = -1;
        do begin
            @(negedge clk);
            waited++;
        end while (txd !== 1'b0 && waited < 200);
        assertions++;
        if (txd !== 1'b0) begin
            failures++;
            $display("FAIL %s start: txd=%b after %0d cycles, required 0", tag, txd, waited);
            return;
        end
        start_cyc = cyc;
        for (int i = 0; i < FRAME; i++) begin
            b = i / FD;
            if (b == 0) exp_txd = 1'b0;
            else if (b == 9) exp_txd = 1'b1;
            else exp_txd = exp_byte[b-1];
            assertions++;
            if (txd !== exp_txd || busy !== 1'b1 || frame_done !== (i == FRAME - 1) ||
                grant_id !== exp_gid) begin
                failures++;
                $display("FAIL %s frame cycle %0d: txd=%b busy=%b frame_done=%b grant_id=%b, required %b 1 %b %b",
                         tag, i + 1, txd, busy, frame_done, grant_id, exp_txd, (i == FRAME - 1), exp_gid);
            end
            @(negedge clk);
        end
        assertions++;
        if (txd !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0 || grant_id !== exp_gid) begin
            failures++;
            $display("FAIL %s idle gap: txd=%b busy=%b frame_done=%b grant_id=%b, required 1 0 0 %b",
                     tag, txd, busy, frame_done, grant_id, exp_gid);
        end
    endtask

    // Sends everything the model still holds; back-to-back starts must be 41 apart.
    task automatic drain(input string tag);
        bit         gid;
        logic [7:0] d;
        int         st;
        int         prev;
        prev = -1;
        while (mdl_q0.size() != 0 || mdl_q1.size() != 0) begin
            predict(gid, d);
            frame_check(gid, d, tag, st);
            if (prev >= 0 && st >= 0) begin
                assertions++;
                if (st - prev !== FRAME + 1) begin
                    failures++;
                    $display("FAIL %s period: start spacing %0d cycles, required %0d", tag, st - prev, FRAME + 1);
                end
            end
            prev = st;
        end
    endtask

    // Called at a falling edge; asserts reset mid-cycle and releases it on a falling edge.
    task automatic pulse_reset(input string tag);
        #2;
        rst = 1'b1;
        drv_q0.delete();
        drv_q1.delete();
        mdl_q0.delete();
        mdl_q1.delete();
        m_last = 1'b1;
        m_gid  = 1'b0;
        #1;
        check_quiet({tag, "_at_assert"});
        repeat (3) begin
            @(negedge clk);
            #2;
            check_quiet({tag, "_held"});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bit         gid;
        logic [7:0] d;
        int         st;
        int         rel;
        #1 rst = 1'b1;
        push(1'b0, 8'($urandom));
        repeat (3) begin
            @(negedge clk);
            #2;
            check_quiet("reset_held");
        end
        @(negedge clk);
        rst = 1'b0;
        rel = cyc;
        predict(gid, d);
        frame_check(gid, d, "first_after_reset", st);
        assertions++;
        if (st !== rel + 1) begin
            failures++;
            $display("FAIL first_acceptance: start cycle %0d, required %0d", st, rel + 1);
        end
    endtask

    task automatic test_single_0x55();
        push(1'b0, 8'h55);
        drain("single_0x55");
    endtask

    task automatic test_contention();
        @(negedge clk);
        pulse_reset("contention_reset");
        push(1'b0, 8'hA1);
        push(1'b1, 8'h3C);
        drain("contention");
    endtask

    task automatic test_round_robin();
        for (int k = 0; k < 2; k++) begin
            push(1'b0, 8'($urandom));
            push(1'b1, 8'($urandom));
        end
        drain("round_robin");
    endtask

    task automatic test_only_req1();
        push(1'b1, 8'h00);
        push(1'b1, 8'hFF);
        push(1'b1, 8'h80);
        drain("only_req1");
    endtask

    task automatic test_reset_midframe();
        bit         gid;
        logic [7:0] d;
        int         waited;
        push(1'b0, 8'($urandom));
        predict(gid, d);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (txd !== 1'b0 && waited < 200);
        repeat (17) @(negedge clk);
        assertions++;
        if (txd !== d[3] || busy !== 1'b1) begin
            failures++;
            $display("FAIL midframe_bit3: txd=%b busy=%b, required %b 1", txd, busy, d[3]);
        end
        pulse_reset("midframe_reset");
        repeat (30) begin
            @(negedge clk);
            #2;
            check_quiet("after_abort");
        end
        push(1'b0, 8'h0F);
        drain("after_abort_0x0F");
    endtask

    task automatic test_idle();
        repeat (100) begin
            @(negedge clk);
            #2;
            check_quiet("idle_100");
        end
    endtask

    task automatic test_random();
        int n0;
        int n1;
        for (int r = 0; r < 6; r++) begin
            n0 = $urandom_range(0, 3);
            n1 = $urandom_range(0, 3);
            if (n0 + n1 == 0) n0 = 1;
            for (int k = 0; k < n0; k++) push(1'b0, 8'($urandom));
            for (int k = 0; k < n1; k++) push(1'b1, 8'($urandom));
            drain("random");
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single_0x55();
        test_contention();
        test_round_robin();
        test_only_req1();
        test_reset_midframe();
        test_idle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
